// File: rtl/truth_table_pkg.sv
// Shared constants, types and the table lookup helper for truth_table_eval.
// Contents:
//   SEL_W_DEF, DEFAULT_TABLE_DEF, RUN_LEN_DEF, CNT_W_DEF - default parameters
//   LUT_MAX_W, SEL_MAX_W - widest table/selector that lookup() supports
//   run_cnt_t - run counter type
//   lookup()  - returns table bit addressed by the selector
package truth_table_pkg;

   localparam int unsigned SEL_W_DEF         = 3;
   localparam logic [7:0]  DEFAULT_TABLE_DEF = 8'hA5;
   localparam int unsigned RUN_LEN_DEF       = 4;
   localparam int unsigned CNT_W_DEF         = 8;

   // lookup() is written for the widest supported table so it has one signature.
   localparam int unsigned SEL_MAX_W = 8;
   localparam int unsigned LUT_MAX_W = 256;

   typedef logic [7:0] run_cnt_t;

   function automatic logic lookup(input logic [LUT_MAX_W-1:0] tbl,
                                   input logic [SEL_MAX_W-1:0] sel);
      return tbl[sel];
   endfunction

endpackage

// File: rtl/truth_table_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears count
//   clr   - synchronous clear; with inc the same edge yields 1
//   inc   - increment request, holds at MAX
//   count - registered counter value
module sat_counter #(
   parameter int unsigned W   = 8,
   parameter int unsigned MAX = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] base_c;
   logic [W-1:0] next_c;

   // Clear applies to the prior value, so a coinciding increment counts from zero.
   always_comb begin
      base_c = clr ? W'(0) : count;
      next_c = base_c;
      if (inc && (base_c != W'(MAX))) begin
         next_c = base_c + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= W'(0);
      end else begin
         count <= next_c;
      end
   end

endmodule

// File: rtl/truth_table_eval.sv
// Registered, programmable N-input truth-table evaluator with valid/ready stream.
// Ports:
//   clk_i, rst_i        - clock (rising) and asynchronous active-high reset
//   cfg_we_i, cfg_table_i - table write; takes effect for the next accepted sample
//   cnt_clr_i           - synchronous clear of hit counter and run counter
//   valid_i, ready_o, data_i - input sample stream (ready_o is combinational)
//   valid_o, ready_i, result_o, run_o - one-deep registered result stream
//   hit_count_o         - saturating count of accepted hits
module truth_table_eval
   import truth_table_pkg::*;
#(
   parameter int unsigned              SEL_W         = SEL_W_DEF,
   parameter logic [(2**SEL_W)-1:0]    DEFAULT_TABLE = DEFAULT_TABLE_DEF,
   parameter int unsigned              RUN_LEN       = RUN_LEN_DEF,
   parameter int unsigned              CNT_W         = CNT_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_we_i,
   input  logic [(2**SEL_W)-1:0]   cfg_table_i,
   input  logic                    cnt_clr_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [SEL_W-1:0]        data_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    result_o,
   output logic                    run_o,
   output logic [CNT_W-1:0]        hit_count_o
);

   localparam int unsigned TBL_W   = 2**SEL_W;
   localparam int unsigned HIT_MAX = (2**CNT_W) - 1;

   logic [TBL_W-1:0] table_q;
   run_cnt_t         run_cnt;
   run_cnt_t         run_base_c;
   logic             accept_c;
   logic             hit_c;
   logic             run_set_c;

   assign ready_o  = !valid_o || ready_i;
   assign accept_c = valid_i && ready_o;
   // Sample reads the table as it stood before any same-cycle write.
   assign hit_c    = lookup(LUT_MAX_W'(table_q), SEL_MAX_W'(data_i));

   // Run counter after this sample equals RUN_LEN iff it is a hit and the
   // (possibly cleared) prior count had already reached RUN_LEN-1.
   always_comb begin
      run_base_c = cnt_clr_i ? run_cnt_t'(0) : run_cnt;
      run_set_c  = hit_c && (run_base_c >= run_cnt_t'(RUN_LEN - 1));
   end

   // Table register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         table_q <= DEFAULT_TABLE;
      end else if (cfg_we_i) begin
         table_q <= cfg_table_i;
      end
   end

   // One-deep output register; result/run only move on accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o  <= 1'b0;
         result_o <= 1'b0;
         run_o    <= 1'b0;
      end else if (accept_c) begin
         valid_o  <= 1'b1;
         result_o <= hit_c;
         run_o    <= run_set_c;
      end else if (ready_i) begin
         valid_o  <= 1'b0;
      end
   end

   // A miss restarts the run, so it is folded into the run counter clear.
   sat_counter #(
      .W   ($bits(run_cnt_t)),
      .MAX (RUN_LEN)
   ) u_run_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (cnt_clr_i || (accept_c && !hit_c)),
      .inc   (accept_c && hit_c),
      .count (run_cnt)
   );

   sat_counter #(
      .W   (CNT_W),
      .MAX (HIT_MAX)
   ) u_hit_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (cnt_clr_i),
      .inc   (accept_c && hit_c),
      .count (hit_count_o)
   );

endmodule

// File: tb/tb_truth_table_eval.sv
// Directed bench for truth_table_eval (SEL_W=3, table A5, RUN_LEN=4, CNT_W=3).
module tb_truth_table_eval;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       cfg_we_i;
   logic [7:0] cfg_table_i;
   logic       cnt_clr_i;
   logic       valid_i;
   logic       ready_o;
   logic [2:0] data_i;
   logic       valid_o;
   logic       ready_i;
   logic       result_o;
   logic       run_o;
   logic [2:0] hit_count_o;

   int total = 0;
   int bad   = 0;

   truth_table_eval #(
      .SEL_W         (3),
      .DEFAULT_TABLE (8'hA5),
      .RUN_LEN       (4),
      .CNT_W         (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_table_i (cfg_table_i),
      .cnt_clr_i   (cnt_clr_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
      .run_o       (run_o),
      .hit_count_o (hit_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_sweep;
      logic [3:0] exp_run;
      exp_sweep = 8'b1010_0101;   // results for selectors 7..0 under table A5

      rst_i = 1'b1; cfg_we_i = 1'b0; cfg_table_i = 8'h00; cnt_clr_i = 1'b0;
      valid_i = 1'b0; data_i = 3'd0; ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_result", 32'(result_o), 32'd0);
      chk("rst_run", 32'(run_o), 32'd0);
      chk("rst_hits", 32'(hit_count_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      rst_i = 1'b0;

      // Sweep all selectors under the default table.
      ready_i = 1'b1;
      valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_i = 3'(i);
         cycle();
         chk($sformatf("sweep_valid_%0d", i), 32'(valid_o), 32'd1);
         chk($sformatf("sweep_result_%0d", i), 32'(result_o), 32'(exp_sweep[i]));
      end
      valid_i = 1'b0;
      cycle();
      chk("drain_valid", 32'(valid_o), 32'd0);
      chk("sweep_hits", 32'(hit_count_o), 32'd4);
      chk("drain_result_hold", 32'(result_o), 32'd1);

      // Table write with a coinciding accept uses the old table.
      cfg_we_i = 1'b1; cfg_table_i = 8'h0F; valid_i = 1'b1; data_i = 3'd5;
      cycle();
      chk("wr_old_table", 32'(result_o), 32'd1);
      cfg_we_i = 1'b0;
      cycle();
      chk("wr_new_table_5", 32'(result_o), 32'd0);
      data_i = 3'd3;
      cycle();
      chk("wr_new_table_3", 32'(result_o), 32'd1);
      chk("wr_hits", 32'(hit_count_o), 32'd6);

      // Backpressure: nothing accepted, output frozen.
      ready_i = 1'b0; data_i = 3'd0;
      #1;
      chk("hold_ready_low", 32'(ready_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk($sformatf("hold_valid_%0d", k), 32'(valid_o), 32'd1);
         chk($sformatf("hold_result_%0d", k), 32'(result_o), 32'd1);
         chk($sformatf("hold_ready_%0d", k), 32'(ready_o), 32'd0);
         data_i = 3'(k + 1);
      end
      chk("hold_hits", 32'(hit_count_o), 32'd6);
      ready_i = 1'b1; data_i = 3'd4;
      #1;
      chk("release_ready", 32'(ready_o), 32'd1);
      cycle();
      chk("release_result_4", 32'(result_o), 32'd0);
      data_i = 3'd1;
      cycle();
      chk("release_result_1", 32'(result_o), 32'd1);
      chk("release_hits", 32'(hit_count_o), 32'd7);

      // Restore default table and clear counters without accepting.
      valid_i = 1'b0; cfg_we_i = 1'b1; cfg_table_i = 8'hA5; cnt_clr_i = 1'b1;
      cycle();
      cfg_we_i = 1'b0; cnt_clr_i = 1'b0;
      chk("clr_valid", 32'(valid_o), 32'd0);
      chk("clr_hits", 32'(hit_count_o), 32'd0);
      chk("clr_result_hold", 32'(result_o), 32'd1);

      // Run detection: 0,2,5,7,7 -> 0,0,0,1,1.
      valid_i = 1'b1;
      exp_run = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         data_i = (i == 0) ? 3'd0 : (i == 1) ? 3'd2 : (i == 2) ? 3'd5 : 3'd7;
         cycle();
         chk($sformatf("run_step_%0d", i), 32'(run_o), 32'(exp_run[i]));
      end
      data_i = 3'd7;
      cycle();
      chk("run_sat", 32'(run_o), 32'd1);
      data_i = 3'd1;
      cycle();
      chk("run_miss", 32'(run_o), 32'd0);
      chk("run_miss_result", 32'(result_o), 32'd0);
      data_i = 3'd0;
      cycle();
      chk("run_restart", 32'(run_o), 32'd0);
      // Run count is 1 now, so three more hits complete a run.
      data_i = 3'd2;
      cycle();
      chk("run_cnt2", 32'(run_o), 32'd0);
      data_i = 3'd5;
      cycle();
      chk("run_cnt3", 32'(run_o), 32'd0);
      data_i = 3'd7;
      cycle();
      chk("run_cnt4", 32'(run_o), 32'd1);
      chk("hits_saturated", 32'(hit_count_o), 32'd7);

      // Clear coinciding with a hit accept counts that hit from zero.
      cnt_clr_i = 1'b1; data_i = 3'd0;
      cycle();
      cnt_clr_i = 1'b0;
      chk("clr_accept_hits", 32'(hit_count_o), 32'd1);
      chk("clr_accept_run", 32'(run_o), 32'd0);
      chk("clr_accept_result", 32'(result_o), 32'd1);

      // Build a run under a modified table, then reset mid-cycle.
      cfg_we_i = 1'b1; cfg_table_i = 8'hFF; data_i = 3'd0;
      cycle();
      cfg_we_i = 1'b0; data_i = 3'd6;
      cycle();
      chk("ff_result_6", 32'(result_o), 32'd1);
      cycle();
      chk("ff_run", 32'(run_o), 32'd1);
      chk("ff_hits", 32'(hit_count_o), 32'd4);
      valid_i = 1'b0; ready_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_valid", 32'(valid_o), 32'd0);
      chk("async_rst_hits", 32'(hit_count_o), 32'd0);
      chk("async_rst_run", 32'(run_o), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = 3'd2;
      cycle();
      chk("post_rst_result_2", 32'(result_o), 32'd1);
      data_i = 3'd6;
      cycle();
      chk("post_rst_result_6", 32'(result_o), 32'd0);
      chk("post_rst_hits", 32'(hit_count_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
